// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the rr_arb_mux arbitrated selector.
// Optional build macro RR_ARB_MUX_FIXED_PRIO_EN selects fixed-priority grant.
package rr_arb_mux_pkg;

    localparam int MAX_CH = 16;

    // Channel index width: clog2 of the channel count, never narrower than 1 bit.
    function automatic int ch_w_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Producer/consumer bundle of rr_arb_mux; slave is the mux side, master the environment side.
interface rr_arb_mux_if #(
    parameter int WIDTH  = 5,
    parameter int NUM_CH = 4
);
    import rr_arb_mux_pkg::*;

    localparam int CH_W = ch_w_f(NUM_CH);

    // Handshake: a beat moves on a channel only in a cycle where its valid and ready are both 1;
    // valid must not depend on ready, data must be held while valid is 1 and ready is 0.
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational grant over a request vector: round-robin from ptr by default,
// lowest-index-wins when RR_ARB_MUX_FIXED_PRIO_EN is defined (no ptr port then).
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_w_f(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
    input  logic [CH_W-1:0]   ptr,
`endif
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
            idx = CH_W'(i);
`else
            // Candidate i positions past the pointer, wrapped into 0..NUM_CH-1.
            sum = {1'b0, ptr} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            idx = sum[CH_W-1:0];
`endif
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrated selector with a one-entry registered output (1-cycle latency, full rate).
// Build macro RR_ARB_MUX_FIXED_PRIO_EN swaps round-robin for fixed lowest-index priority.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int NUM_CH = 4
) (
    input logic         Clk,
    input logic         Rst_n,
    rr_arb_mux_if.slave bus
);

    localparam int CH_W = ch_w_f(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("rr_arb_mux: NUM_CH must be within 1..16");
    end

    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              load_ok;
    logic              xfer;
    logic [WIDTH-1:0]  sel_data;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
    logic [CH_W-1:0]   ptr_q,       ptr_d;
`endif

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (bus.in_valid),
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
        .ptr     (ptr_q),
`endif
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load_ok = !out_valid_q || bus.out_ready;
    assign xfer    = gnt_any && load_ok;

    // Ready is held low while reset is asserted so nothing looks accepted during reset.
    assign bus.in_ready  = gnt & {NUM_CH{load_ok && Rst_n}};
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = gnt_idx;
        end
    end

`ifndef RR_ARB_MUX_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

endmodule
